// File: rtl/cnt_seq_ctrl.sv
// Modulo counter sequencer with a registered terminal-count wrap, start/pause/stop control,
// one-shot or continuous modes, a terminal-count strobe and a saturating wrap tally.
module cnt_seq_ctrl #(
    parameter int WIDTH         = 4,
    parameter int DEFAULT_LIMIT = 10,
    parameter int WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              cfg_we,
    input  logic [WIDTH-1:0]  cfg_limit,
    input  logic              cfg_mode,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              tc_pulse,
    output logic [WRAP_W-1:0] wraps,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [WIDTH-1:0]  DEF_LIM  = WIDTH'(DEFAULT_LIMIT);
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    limit_q, limit_d;
    logic                mode_q, mode_d;
    logic                tc_q, tc_d;
    logic [WRAP_W-1:0]   wraps_q, wraps_d;
    logic                cfg_err_q, cfg_err_d;
    logic                cfg_ok;

    // Config is only legal while nothing is counting, which keeps count <= limit at all times.
    assign cfg_ok = cfg_we && ((state_q == IDLE) || (state_q == DONE)) && (cfg_limit != '0);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        tc_d      = 1'b0;
        wraps_d   = wraps_q;
        cfg_err_d = cfg_we && !cfg_ok;

        if (cfg_ok) begin
            limit_d = cfg_limit;
            mode_d  = cfg_mode;
        end

        case (state_q)
            IDLE: begin
                count_d = '0;
                if (!stop && !pause && start) begin
                    state_d = RUN;
                    wraps_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (count_q == limit_q) begin
                    tc_d    = 1'b1;
                    wraps_d = (wraps_q == WRAP_MAX) ? WRAP_MAX : wraps_q + WRAP_W'(1);
                    if (mode_q) begin
                        count_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!pause && start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!pause && start) begin
                    state_d = RUN;
                    count_d = '0;
                    wraps_d = '0;
                end else if (cfg_ok) begin
                    count_d = cfg_limit;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            limit_q   <= DEF_LIM;
            mode_q    <= 1'b0;
            tc_q      <= 1'b0;
            wraps_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            tc_q      <= tc_d;
            wraps_q   <= wraps_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign count    = count_q;
    assign busy     = (state_q == RUN) || (state_q == PAUSE);
    assign done     = (state_q == DONE);
    assign tc_pulse = tc_q;
    assign wraps    = wraps_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed self-checking bench for cnt_seq_ctrl.
module tb_cnt_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_limit = 4'd0;
    logic       cfg_mode = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] count;
    logic       busy, done, tc_pulse, cfg_err;
    logic [7:0] wraps;

    int checks = 0;
    int failures = 0;

    cnt_seq_ctrl #(.WIDTH(4), .DEFAULT_LIMIT(10), .WRAP_W(8)) dut (
        .clk(clk), .i_rst(rst), .cfg_we(cfg_we), .cfg_limit(cfg_limit), .cfg_mode(cfg_mode),
        .start(start), .pause(pause), .stop(stop), .count(count), .busy(busy), .done(done),
        .tc_pulse(tc_pulse), .wraps(wraps), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cfg_we = 0; start = 0; pause = 0; stop = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 rst = 1;
        #2 rst = 0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 rst = 1;
        #1;
        checks++;
        if ({count, busy, done, tc_pulse, wraps, cfg_err} !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: got count=%0d busy=%b done=%b tc=%b wraps=%0d cfg_err=%b, want all 0",
                     count, busy, done, tc_pulse, wraps, cfg_err);
        end
        #1 rst = 0;
        tick();
    endtask

    task automatic test_continuous();
        logic [3:0] exp_cnt;
        logic [7:0] exp_wr;
        logic       exp_tc;
        cfg_we = 1; cfg_limit = 4'd10; cfg_mode = 1; start = 1;
        tick();
        clear_inputs();
        checks++;
        if (count !== 4'd0 || busy !== 1'b1 || wraps !== 8'd0) begin
            failures++;
            $display("FAIL cont_start: got count=%0d busy=%b wraps=%0d, want 0 1 0", count, busy, wraps);
        end
        exp_cnt = 0; exp_wr = 0;
        for (int i = 0; i < 25; i++) begin
            exp_tc  = (exp_cnt == 4'd10);
            exp_cnt = exp_tc ? 4'd0 : exp_cnt + 4'd1;
            if (exp_tc) exp_wr++;
            tick();
            checks++;
            if (count !== exp_cnt || tc_pulse !== exp_tc || wraps !== exp_wr) begin
                failures++;
                $display("FAIL cont_seq[%0d]: got count=%0d tc=%b wraps=%0d, want %0d %b %0d",
                         i, count, tc_pulse, wraps, exp_cnt, exp_tc, exp_wr);
            end
        end
        stop = 1;
        tick();
        clear_inputs();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop: got count=%0d busy=%b, want 0 0", count, busy);
        end
    endtask

    task automatic test_oneshot();
        cfg_we = 1; cfg_limit = 4'd3; cfg_mode = 0;
        tick();
        clear_inputs();
        start = 1;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (count !== 4'(i) || busy !== 1'b1 || done !== 1'b0 || tc_pulse !== 1'b0) begin
                failures++;
                $display("FAIL oneshot_cnt[%0d]: got count=%0d busy=%b done=%b tc=%b, want %0d 1 0 0",
                         i, count, busy, done, tc_pulse, i);
            end
            tick();
        end
        checks++;
        if (count !== 4'd3 || done !== 1'b1 || tc_pulse !== 1'b1 || busy !== 1'b0 || wraps !== 8'd1) begin
            failures++;
            $display("FAIL oneshot_done: got count=%0d done=%b tc=%b busy=%b wraps=%0d, want 3 1 1 0 1",
                     count, done, tc_pulse, busy, wraps);
        end
        tick();
        checks++;
        if (count !== 4'd3 || done !== 1'b1 || tc_pulse !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_hold: got count=%0d done=%b tc=%b, want 3 1 0", count, done, tc_pulse);
        end
        start = 1;
        tick();
        clear_inputs();
        checks++;
        if (count !== 4'd0 || done !== 1'b0 || wraps !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_restart: got count=%0d done=%b wraps=%0d busy=%b, want 0 0 0 1",
                     count, done, wraps, busy);
        end
        stop = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_pause();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd3, 4'd4, 4'd5, 4'd0};
        cfg_we = 1; cfg_limit = 4'd5; cfg_mode = 1; start = 1;
        tick();
        clear_inputs();
        tick();
        tick();
        pause = 1;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (count !== 4'd2 || busy !== 1'b1) begin
                failures++;
                $display("FAIL pause_hold[%0d]: got count=%0d busy=%b, want 2 1", i, count, busy);
            end
            tick();
        end
        start = 1; pause = 1;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (count !== 4'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pause_over_start: got count=%0d busy=%b, want 2 1", count, busy);
        end
        start = 1;
        tick();
        clear_inputs();
        checks++;
        if (count !== 4'd2) begin
            failures++;
            $display("FAIL resume_edge: got count=%0d, want 2", count);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (count !== exp_seq[i] || tc_pulse !== (i == 3)) begin
                failures++;
                $display("FAIL resume_seq[%0d]: got count=%0d tc=%b, want %0d %b",
                         i, count, tc_pulse, exp_seq[i], (i == 3));
            end
        end
        stop = 1; start = 1;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_over_start: got count=%0d busy=%b, want 0 0", count, busy);
        end
    endtask

    task automatic test_cfg_reject();
        do_reset();
        start = 1;
        tick();
        clear_inputs();
        cfg_we = 1; cfg_limit = 4'd7; cfg_mode = 1;
        tick();
        clear_inputs();
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL cfg_err_run: got %b, want 1", cfg_err);
        end
        tick();
        checks++;
        if (cfg_err !== 1'b0 || count !== 4'd2) begin
            failures++;
            $display("FAIL cfg_err_clear: got cfg_err=%b count=%0d, want 0 2", cfg_err, count);
        end
        repeat (8) tick();
        checks++;
        if (count !== 4'd10 || busy !== 1'b1) begin
            failures++;
            $display("FAIL limit_kept: got count=%0d busy=%b, want 10 1", count, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || count !== 4'd10) begin
            failures++;
            $display("FAIL limit_kept_done: got done=%b count=%0d, want 1 10", done, count);
        end
        stop = 1;
        tick();
        clear_inputs();
        cfg_we = 1; cfg_limit = 4'd0; cfg_mode = 1;
        tick();
        clear_inputs();
        checks++;
        if (cfg_err !== 1'b1) begin
            failures++;
            $display("FAIL cfg_err_zero: got %b, want 1", cfg_err);
        end
        start = 1;
        tick();
        clear_inputs();
        repeat (10) tick();
        checks++;
        if (count !== 4'd10 || busy !== 1'b1 || cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_nochange: got count=%0d busy=%b cfg_err=%b, want 10 1 0", count, busy, cfg_err);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL zero_mode_kept: got done=%b, want 1", done);
        end
        stop = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_async_reset();
        start = 1;
        tick();
        clear_inputs();
        repeat (6) tick();
        checks++;
        if (count !== 4'd6) begin
            failures++;
            $display("FAIL pre_reset_count: got %0d, want 6", count);
        end
        #2 rst = 1;
        #1;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
        end
        #1 rst = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (count !== 4'd0 || tc_pulse !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_idle[%0d]: got count=%0d tc=%b busy=%b, want 0 0 0",
                         i, count, tc_pulse, busy);
            end
        end
        start = 1;
        tick();
        clear_inputs();
        repeat (10) tick();
        checks++;
        if (count !== 4'd10 || done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_limit: got count=%0d done=%b, want 10 0", count, done);
        end
        stop = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        int         bad;
        cfg_we = 1; cfg_limit = 4'd1; cfg_mode = 1; start = 1;
        tick();
        clear_inputs();
        exp_cnt = 0;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            exp_cnt = (exp_cnt == 4'd1) ? 4'd0 : 4'd1;
            tick();
            if (count !== exp_cnt) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sat_count_seq: got %0d mismatching cycles, want 0", bad);
        end
        checks++;
        if (wraps !== 8'd255) begin
            failures++;
            $display("FAIL sat_wraps: got %0d, want 255", wraps);
        end
        exp_cnt = (exp_cnt == 4'd1) ? 4'd0 : 4'd1;
        tick();
        checks++;
        if (count !== exp_cnt || wraps !== 8'd255 || busy !== 1'b1) begin
            failures++;
            $display("FAIL sat_continue: got count=%0d wraps=%0d busy=%b, want %0d 255 1",
                     count, wraps, busy, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_oneshot();
        test_pause();
        test_cfg_reject();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Synchronous sequencer for a free-running modulo counter. It replaces the combinational "count == N drives async reset" feedback with a registered terminal-count wrap.
- Owns the counter register and a programmable limit, and provides start/pause/stop control, one-shot or continuous modes, a terminal-count pulse and a wrap tally.
- Sits between software/control logic and any consumer of the count value.

Parameters:
- WIDTH, 4, counter and limit width in bits.
- DEFAULT_LIMIT, 10, limit register value after reset. Must be in 1..2^WIDTH-1.
- WRAP_W, 8, width of the saturating wrap tally.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_limit  in  WIDTH  new terminal value.
- cfg_mode  in  1  0 = one-shot, 1 = continuous.
- start  in  1  begin a run, or resume from pause.
- pause  in  1  freeze the count.
- stop  in  1  abort to idle.
- count  out  WIDTH  current count.
- busy  out  1  high in RUN or PAUSE.
- done  out  1  high in DONE.
- tc_pulse  out  1  one-cycle terminal-count strobe.
- wraps  out  WRAP_W  completed periods since last start; saturates at all-ones.
- cfg_err  out  1  one-cycle strobe when a config write is rejected.

Behaviour:
- Reset values (asynchronous, immediate, also mid-run):
  - state = IDLE; count = 0; done = 0; busy = 0; tc_pulse = 0; wraps = 0; cfg_err = 0.
  - limit register = DEFAULT_LIMIT; mode register = 0.
- All outputs are registered or decoded directly from the state register. There are no combinational paths from inputs to outputs.
- Configuration:
  - cfg_we is accepted only in IDLE or DONE, and only if cfg_limit != 0. The limit and mode registers update on that edge.
  - In any other case the write is ignored and cfg_err = 1 for the next cycle.
  - cfg_we together with start in IDLE: the new config applies to the run being started.
- Control priority, same cycle: stop > pause > start.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - count = 0.
  - start -> RUN; count stays 0 on this edge; wraps <= 0.
  - pause and stop have no effect.
- RUN, evaluated per edge:
  - stop -> IDLE, count <= 0.
  - else pause -> PAUSE, count holds.
  - else if count == limit:
    - tc_pulse <= 1 and wraps <= wraps+1 (saturating).
    - mode 1: count <= 0, stay in RUN.
    - mode 0: -> DONE, count holds at limit, done <= 1.
  - else count <= count+1.
  - start while in RUN is ignored.
- PAUSE:
  - stop -> IDLE, count <= 0.
  - else start -> RUN; counting resumes on the following edge from the held value.
  - Otherwise count holds.
- DONE:
  - count = limit, done = 1.
  - start -> RUN with count <= 0, done <= 0, wraps <= 0.
  - stop -> IDLE with count <= 0, done <= 0.
- Timing:
  - Continuous period is limit+1 cycles.
  - tc_pulse is high in exactly the cycle after count showed limit; in mode 1, count reads 0 in that cycle.
  - One-shot from start edge to done = 1 takes limit+1 edges.
- Arithmetic: increment is modulo 2^WIDTH, but the count never exceeds limit, because the limit compare has priority over the increment.
- Changing the limit while RUN or PAUSE is impossible (rejected), so the count can never be above limit.

Test Plan:
- Reset default, mode 1, start: count sequence 0,1,...,10,0,1; tc_pulse high exactly in the cycle count returns to 0; period 11 cycles; wraps increments 1,2,...
- Config limit=3 mode=0, start: count 0,1,2,3 then held at 3; done=1 and tc_pulse=1 in the same cycle; busy drops; a later start restarts from 0 with done=0 and wraps=0.
- Mode 1 limit=5: pause at count=2 holds 2 for 4 cycles; start resumes 3,4,5,0; start+pause in the same cycle keeps PAUSE; stop+start in the same cycle -> IDLE, count=0.
- Rejected config: cfg_we during RUN with limit=7 -> cfg_err one cycle, limit stays 10; cfg_we limit=0 in IDLE -> cfg_err, no change.
- Asynchronous i_rst pulse mid-cycle during RUN at count=6 -> count=0, state IDLE and limit=10 before the next clk edge; no tc_pulse afterwards.
- Saturation: limit=1, mode 1, run 600 cycles -> wraps stops at 255 and counting continues.
